maze_ram_arbiter: RTL and testbench
===================================

Name: maze_ram_arbiter

Overview:
- Shares the single read port of the maze tile RAM (1 bit per tile: 0 = floor, 1 = wall) between three requesters.
  - Port 0: player movement logic.
  - Port 1: VGA renderer.
  - Port 2: maze solver/generator read-back.
- Issues one RAM address per cycle using round-robin arbitration.
- Tracks the RAM read latency and returns each tile bit to the requester that asked for it, with a per-port valid strobe.
- Sits between the requesters and the maze RAM in the top level.

Parameters:
- WIDTH, 10: maze width in tiles.
- HEIGHT, 10: maze height in tiles.
- RAM_LATENCY, 2: cycles from ram_address registered to ram_data valid. Legal range 1..4.

Ports:
- clock  input  1  system clock; all logic on posedge.
- reset_n  input  1  synchronous, active-low reset.
- port_enable  input  3  per-port enable mask. A disabled port's req is ignored.
- req  input  3  request per port. Held high until the matching gnt bit is seen.
- addr  input  33  packed addresses. Port k uses bits [11k+10:11k].
- gnt  output  3  one-hot, combinational. High in the cycle the port's request is accepted.
- rd_valid  output  3  one-hot. Pulses one cycle when the port's tile bit is on rd_data.
- rd_data  output  1  returned tile bit, shared by all ports.
- ram_address  output  11  registered address to the maze RAM.
- ram_data  input  1  RAM read data.
- busy  output  1  high while any read is in flight.

Behaviour:
- Reset (reset_n low at posedge) sets:
  - ram_address = 0, rd_valid = 0, rd_data = 0, busy = 0;
  - round-robin pointer last = 2, so port 0 has top priority next;
  - tag pipeline cleared.
- gnt is 0 whenever reset_n is low. In-flight reads at reset are discarded: no rd_valid is ever produced for them.
- Eligible port k: req[k] & port_enable[k].
- Arbitration, every cycle:
  - Search order is last+1, last+2, last+3 (mod 3). The first eligible port wins and gets gnt[k] = 1 in that cycle.
  - At the clock edge: last <= k, ram_address <= addr_k.
  - If no port is eligible, gnt = 0 and last and ram_address hold.
- Throughput: one grant per cycle, fully pipelined. No stall. Requests from different ports may be back-to-back.
- A requester that keeps req high after its grant is re-arbitrated as a new request.
- Tag pipeline has RAM_LATENCY+1 stages. Each stage holds {valid, port[1:0], oob}.
  - Stage 0 is loaded at the grant edge.
  - At the last stage, when valid = 1:
    - rd_valid[port] = 1;
    - rd_data = oob ? 1 : ram_data.
  - Response latency: grant in cycle N gives rd_valid in cycle N+RAM_LATENCY+1 (N+3 at default).
- Out-of-bounds address (addr_k >= WIDTH*HEIGHT, compared at 11-bit width):
  - The request is still granted and still answered at the normal latency.
  - oob is set, so rd_data = 1 (wall).
  - ram_address is still loaded.
- rd_data outside rd_valid cycles: 0.
- busy = OR of the valid bits over all tag stages.
- Responses are delivered strictly in grant order. No reordering.
- port_enable is sampled combinationally every cycle. Clearing a bit does not cancel that port's already-granted in-flight reads.
- Simultaneous grant and response in the same cycle is normal pipeline operation and must be supported.

Test Plan:
- Reset, then req = 3'b111, all enabled, addr0 = 5, addr1 = 17, addr2 = 42, requests held until granted → gnt sequence 001, 010, 100 in cycles 0, 1, 2; ram_address 5, 17, 42; rd_valid 001, 010, 100 in cycles 3, 4, 5.
- Single port 1 request, addr = 11, RAM preloaded tile 11 = 0 → gnt[1] in cycle N; rd_valid = 010 with rd_data = 0 in cycle N+3; busy high for cycles N+1..N+3.
- Port 0 with addr = 100 (WIDTH*HEIGHT = 100) → granted; rd_valid[0] after 3 cycles with rd_data = 1 even though ram_data = 0.
- port_enable = 3'b101 with req = 3'b111 → port 1 never granted; ports 0 and 2 alternate 001, 100, 001, 100.
- Grant port 2, then assert reset_n = 0 for one cycle in cycle N+1 → no rd_valid in cycles N+2..N+5; gnt = 0 during reset; first post-reset grant goes to port 0.
- RAM_LATENCY = 4 build, continuous req on port 0 with incrementing addresses → one rd_valid per cycle starting in cycle 5; rd_data matches the RAM contents in address order.

Source files
------------

// File: rtl/maze_ram_arbiter.sv
// -----------------------------------------------------------------------------
// maze_ram_arbiter
//
// Shares the single read port of the maze tile RAM (1 bit per tile,
// 0 = floor, 1 = wall) between three requesters:
//   port 0 - player movement logic
//   port 1 - VGA renderer
//   port 2 - maze solver / generator read-back
//
// One address is issued per cycle under round-robin arbitration. A tag
// pipeline follows each read through the RAM latency, so the returned tile
// bit goes to the port that asked for it, in grant order.
//
// Ports:
//   clock        system clock, all logic on posedge
//   reset_n      synchronous active-low reset
//   port_enable  per-port enable mask; a disabled port's req is ignored
//   req          per-port request, held until the matching gnt is seen
//   addr         packed tile addresses, port k uses bits [11k+10:11k]
//   gnt          one-hot combinational grant
//   rd_valid     one-hot strobe, the port's tile bit is on rd_data
//   rd_data      returned tile bit (0 outside rd_valid cycles)
//   ram_address  registered address to the maze RAM
//   ram_data     RAM read data, RAM_LATENCY cycles after ram_address
//   busy         high while any read is in flight
// -----------------------------------------------------------------------------
module maze_ram_arbiter #(
    parameter int WIDTH       = 10,
    parameter int HEIGHT      = 10,
    parameter int RAM_LATENCY = 2
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [2:0]  port_enable,
    input  logic [2:0]  req,
    input  logic [32:0] addr,
    output logic [2:0]  gnt,
    output logic [2:0]  rd_valid,
    output logic        rd_data,
    output logic [10:0] ram_address,
    input  logic        ram_data,
    output logic        busy
);

    // One stage for the ram_address register plus RAM_LATENCY RAM stages.
    localparam int          STAGES     = RAM_LATENCY + 1;
    localparam int          LAST       = STAGES - 1;
    localparam logic [10:0] TILE_COUNT = 11'(WIDTH * HEIGHT);

    typedef struct packed {
        logic       valid;
        logic [1:0] port;
        logic       oob;
    } tag_t;

    tag_t        tags [STAGES];
    logic [1:0]  last;
    logic [2:0]  eligible;
    logic [10:0] port_addr [3];
    logic [1:0]  order [3];
    logic        win_valid;
    logic [1:0]  win_port;
    logic [10:0] win_addr;
    logic        win_oob;

    assign eligible = req & port_enable;

    // Round-robin arbitration: search last+1, last+2, last+3 (mod 3).
    // NOTE: every variable driven here gets a default first so no latch is inferred.
    always_comb begin
        win_valid = 1'b0;
        win_port  = 2'd0;
        gnt       = 3'b000;
        for (int k = 0; k < 3; k++) begin
            port_addr[k] = addr[11*k +: 11];
        end
        case (last)
            2'd0:    begin order[0] = 2'd1; order[1] = 2'd2; order[2] = 2'd0; end
            2'd1:    begin order[0] = 2'd2; order[1] = 2'd0; order[2] = 2'd1; end
            default: begin order[0] = 2'd0; order[1] = 2'd1; order[2] = 2'd2; end
        endcase
        // No grant may be issued while reset is asserted.
        if (reset_n) begin
            for (int i = 2; i >= 0; i--) begin
                if (eligible[order[i]]) begin
                    win_valid = 1'b1;
                    win_port  = order[i];
                end
            end
        end
        if (win_valid) begin
            gnt[win_port] = 1'b1;
        end
        win_addr = port_addr[win_port];
        win_oob  = (win_addr >= TILE_COUNT);
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the values from before the edge.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            last        <= 2'd2;
            ram_address <= '0;
            // NOTE: the tag pipeline is control state, not storage; clearing its
            // valid bits is what discards reads in flight at reset.
            for (int s = 0; s < STAGES; s++) begin
                tags[s] <= '0;
            end
        end else begin
            if (win_valid) begin
                last        <= win_port;
                ram_address <= win_addr;
            end
            tags[0] <= '{valid: win_valid, port: win_port, oob: win_oob};
            for (int s = 1; s < STAGES; s++) begin
                tags[s] <= tags[s-1];
            end
        end
    end

    // Response side: the last tag stage lines up with ram_data.
    always_comb begin
        rd_valid = 3'b000;
        rd_data  = 1'b0;
        busy     = 1'b0;
        if (tags[LAST].valid) begin
            rd_valid[tags[LAST].port] = 1'b1;
            // Out-of-bounds tiles read back as wall regardless of the RAM.
            rd_data = tags[LAST].oob | ram_data;
        end
        for (int s = 0; s < STAGES; s++) begin
            busy = busy | tags[s].valid;
        end
    end

endmodule

// File: tb/tb_maze_ram_arbiter.sv
// -----------------------------------------------------------------------------
// tb_maze_ram_arbiter
//
// Bench for maze_ram_arbiter at default parameters (10x10 maze, RAM latency 2).
// A behavioural RAM answers ram_address after RAM_LATENCY cycles. A reference
// model tracks the round-robin pointer and a queue of expected responses
// (port, tile bit, due cycle) and compares every DUT output each cycle.
// A vector table and a few hand-written sequences cover the directed cases,
// followed by a randomized run.
// -----------------------------------------------------------------------------
module tb_maze_ram_arbiter;

    localparam int L     = 2;
    localparam int TILES = 100;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [2:0]  port_enable;
    logic [2:0]  req;
    logic [32:0] addr;
    logic [2:0]  gnt;
    logic [2:0]  rd_valid;
    logic        rd_data;
    logic [10:0] ram_address;
    logic        ram_data;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    always #5 clock = ~clock;

    maze_ram_arbiter #(.WIDTH(10), .HEIGHT(10), .RAM_LATENCY(L)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .port_enable (port_enable),
        .req         (req),
        .addr        (addr),
        .gnt         (gnt),
        .rd_valid    (rd_valid),
        .rd_data     (rd_data),
        .ram_address (ram_address),
        .ram_data    (ram_data),
        .busy        (busy)
    );

    // Behavioural maze RAM: data for an address appears L cycles after the
    // address is presented on ram_address.
    logic        mem  [2048];
    logic [10:0] hist [L];

    always @(posedge clock) begin
        hist[0] <= ram_address;
        for (int i = 1; i < L; i++) hist[i] <= hist[i-1];
    end
    assign ram_data = mem[hist[L-1]];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int   port;
        logic data;
        int   due;
    } resp_t;

    resp_t       q[$];
    int          last_m  = 2;
    logic [10:0] ra_m    = '0;
    int          cyc     = 0;
    int          win_m   = -1;
    bit          model_on = 1'b0;

    always @(negedge clock) begin
        logic [2:0] exp_gnt;
        logic [2:0] exp_rv;
        logic       exp_rd;
        exp_gnt = '0;
        exp_rv  = '0;
        exp_rd  = 1'b0;
        win_m   = -1;
        if (reset_n === 1'b1) begin
            for (int i = 1; i <= 3; i++) begin
                int k;
                k = (last_m + i) % 3;
                if (win_m < 0 && req[k] && port_enable[k]) win_m = k;
            end
        end
        if (win_m >= 0) exp_gnt[win_m] = 1'b1;
        if (q.size() > 0 && q[0].due == cyc) begin
            exp_rv[q[0].port] = 1'b1;
            exp_rd            = q[0].data;
        end
        if (model_on) begin
            check("model_gnt", 32'(gnt), 32'(exp_gnt));
            check("model_rd_valid", 32'(rd_valid), 32'(exp_rv));
            check("model_rd_data", 32'(rd_data), 32'(exp_rd));
            check("model_busy", 32'(busy), 32'(q.size() > 0));
            check("model_ram_address", 32'(ram_address), 32'(ra_m));
        end
    end

    always @(posedge clock) begin
        if (reset_n !== 1'b1) begin
            last_m = 2;
            ra_m   = '0;
            q.delete();
        end else begin
            if (q.size() > 0 && q[0].due == cyc) void'(q.pop_front());
            if (win_m >= 0) begin
                logic [10:0] a;
                resp_t       r;
                a      = addr[11*win_m +: 11];
                r.port = win_m;
                r.data = (int'(a) >= TILES) ? 1'b1 : mem[a];
                r.due  = cyc + L + 1;
                q.push_back(r);
                last_m = win_m;
                ra_m   = a;
            end
        end
        cyc++;
    end

    // ---------------- directed vectors ----------------
    typedef struct {
        logic [2:0]  en;
        logic [2:0]  rq;
        logic [2:0]  gnt;
        logic [2:0]  rv;
        logic        rd;
        logic [10:0] ra;
    } vec_t;

    vec_t vecs [14];

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        // cycles 0-5: all three ports requesting, each drops after its grant
        vecs[0]  = '{3'b111, 3'b111, 3'b001, 3'b000, 1'b0, 11'd0};
        vecs[1]  = '{3'b111, 3'b110, 3'b010, 3'b000, 1'b0, 11'd5};
        vecs[2]  = '{3'b111, 3'b100, 3'b100, 3'b000, 1'b0, 11'd17};
        vecs[3]  = '{3'b111, 3'b000, 3'b000, 3'b001, 1'b1, 11'd42};
        vecs[4]  = '{3'b111, 3'b000, 3'b000, 3'b010, 1'b0, 11'd42};
        vecs[5]  = '{3'b111, 3'b000, 3'b000, 3'b100, 1'b0, 11'd42};
        // cycles 6-13: port 1 disabled, ports 0 and 2 alternate
        vecs[6]  = '{3'b101, 3'b111, 3'b001, 3'b000, 1'b0, 11'd42};
        vecs[7]  = '{3'b101, 3'b111, 3'b100, 3'b000, 1'b0, 11'd5};
        vecs[8]  = '{3'b101, 3'b111, 3'b001, 3'b000, 1'b0, 11'd42};
        vecs[9]  = '{3'b101, 3'b111, 3'b100, 3'b001, 1'b1, 11'd5};
        vecs[10] = '{3'b101, 3'b000, 3'b000, 3'b100, 1'b0, 11'd42};
        vecs[11] = '{3'b101, 3'b000, 3'b000, 3'b001, 1'b1, 11'd42};
        vecs[12] = '{3'b101, 3'b000, 3'b000, 3'b100, 1'b0, 11'd42};
        vecs[13] = '{3'b101, 3'b000, 3'b000, 3'b000, 1'b0, 11'd42};

        for (int i = 0; i < 2048; i++) mem[i] = 1'($urandom);
        mem[5]   = 1'b1;
        mem[17]  = 1'b0;
        mem[42]  = 1'b0;
        mem[11]  = 1'b0;
        mem[100] = 1'b0;

        reset_n     = 1'b0;
        port_enable = 3'b111;
        req         = 3'b000;
        addr        = '0;
        repeat (2) @(posedge clock);
        #1;
        reset_n  = 1'b1;
        model_on = 1'b1;

        // Reset state, before any request.
        @(negedge clock);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_rd_valid", 32'(rd_valid), 32'd0);
        check("reset_ram_address", 32'(ram_address), 32'd0);
        next_cycle();

        addr = {11'd42, 11'd17, 11'd5};
        for (int i = 0; i < 14; i++) begin
            port_enable = vecs[i].en;
            req         = vecs[i].rq;
            @(negedge clock);
            check($sformatf("vec%0d_gnt", i), 32'(gnt), 32'(vecs[i].gnt));
            check($sformatf("vec%0d_rd_valid", i), 32'(rd_valid), 32'(vecs[i].rv));
            check($sformatf("vec%0d_rd_data", i), 32'(rd_data), 32'(vecs[i].rd));
            check($sformatf("vec%0d_ram_address", i), 32'(ram_address), 32'(vecs[i].ra));
            next_cycle();
        end

        // Single port 1 read of floor tile 11.
        port_enable = 3'b111;
        req  = 3'b010;
        addr = {11'd0, 11'd11, 11'd0};
        @(negedge clock);
        check("p1_gnt", 32'(gnt), 32'b010);
        for (int d = 1; d <= 4; d++) begin
            next_cycle();
            req = 3'b000;
            @(negedge clock);
            check($sformatf("p1_busy_n%0d", d), 32'(busy), 32'(d <= 3));
            check($sformatf("p1_rd_valid_n%0d", d), 32'(rd_valid), (d == 3) ? 32'b010 : 32'b000);
            check($sformatf("p1_rd_data_n%0d", d), 32'(rd_data), 32'd0);
        end

        // Port 0 at the first out-of-bounds address reads back as wall.
        next_cycle();
        req  = 3'b001;
        addr = {11'd0, 11'd0, 11'd100};
        @(negedge clock);
        check("oob_gnt", 32'(gnt), 32'b001);
        for (int d = 1; d <= 4; d++) begin
            next_cycle();
            req = 3'b000;
            @(negedge clock);
            if (d == 1) check("oob_ram_address", 32'(ram_address), 32'd100);
            check($sformatf("oob_rd_valid_n%0d", d), 32'(rd_valid), (d == 3) ? 32'b001 : 32'b000);
            check($sformatf("oob_rd_data_n%0d", d), 32'(rd_data), (d == 3) ? 32'd1 : 32'd0);
        end

        // Reset one cycle after a port 2 grant discards that read.
        next_cycle();
        req  = 3'b100;
        addr = {11'd7, 11'd0, 11'd0};
        @(negedge clock);
        check("rst_seq_gnt_port2", 32'(gnt), 32'b100);
        next_cycle();
        reset_n = 1'b0;
        req     = 3'b111;
        @(negedge clock);
        check("rst_seq_gnt_in_reset", 32'(gnt), 32'b000);
        next_cycle();
        reset_n = 1'b1;
        req     = 3'b000;
        for (int d = 2; d <= 5; d++) begin
            if (d > 2) next_cycle();
            @(negedge clock);
            check($sformatf("rst_seq_rd_valid_n%0d", d), 32'(rd_valid), 32'd0);
        end
        next_cycle();
        req = 3'b111;
        @(negedge clock);
        check("rst_seq_first_gnt", 32'(gnt), 32'b001);
        next_cycle();
        req = 3'b000;

        // Randomized traffic against the reference model.
        for (int i = 0; i < 400; i++) begin
            logic [10:0] a [3];
            for (int k = 0; k < 3; k++) begin
                a[k] = ($urandom_range(0, 7) == 0) ? 11'($urandom_range(0, 2047))
                                                   : 11'($urandom_range(0, 110));
            end
            port_enable = 3'($urandom);
            req         = 3'($urandom);
            addr        = {a[2], a[1], a[0]};
            next_cycle();
        end
        req = 3'b000;
        repeat (6) next_cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
